// File: rtl/adder_cmd_master_if.sv
// Signal bundle around adder_cmd_master: command input, adder register bus and result output.
// The master modport is the controller's view; slave is the view of whatever surrounds it.
interface adder_cmd_master_if #(
  parameter int N = 4
);
  logic         s_valid;
  logic         s_ready;
  logic [N-1:0] s_data1;
  logic [N-1:0] s_data2;
  logic         s_cin;
  logic [2:0]   o_addr;
  logic [N-1:0] o_data;
  logic         o_we;
  logic         o_start;
  logic [N-1:0] i_data;
  logic         i_ack;
  logic         i_ready;
  logic         m_valid;
  logic         m_ready;
  logic [N-1:0] m_result;
  logic         m_cout;
  logic         o_timeout;

  modport master (
    input  s_valid, s_data1, s_data2, s_cin, i_data, i_ack, i_ready, m_ready,
    output s_ready, o_addr, o_data, o_we, o_start, m_valid, m_result, m_cout, o_timeout
  );

  modport slave (
    output s_valid, s_data1, s_data2, s_cin, i_data, i_ack, i_ready, m_ready,
    input  s_ready, o_addr, o_data, o_we, o_start, m_valid, m_result, m_cout, o_timeout
  );
endinterface

// File: rtl/adder_cmd_master.sv
// Drives a register-mapped full adder: writes both operands and carry-in, starts it,
// waits for ready, reads sum and carry back and presents them on a valid/ready output.
module adder_cmd_master #(
  parameter int N       = 4,
  parameter int TIMEOUT = 15
) (
  input  logic               i_clk,
  input  logic               i_rstn,
  adder_cmd_master_if.master bus
);
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] WAIT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [3:0] {
    IDLE, WR_D1, ACK_D1, WR_D2, ACK_D2, WR_CIN, ACK_CIN,
    START, WAIT_RDY, RD_RES, RD_COUT, RD_LAST, OUT
  } state_t;

  state_t        state;
  logic [N-1:0]  data1;
  logic [N-1:0]  data2;
  logic          cin;
  logic [CW-1:0] wait_cnt;
  logic          awaited;

  // The four waiting states share one timeout path; only the awaited strobe differs.
  assign awaited = (state == WAIT_RDY) ? bus.i_ready : bus.i_ack;

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state         <= IDLE;
      data1         <= '0;
      data2         <= '0;
      cin           <= 1'b0;
      wait_cnt      <= '0;
      bus.s_ready   <= 1'b0;
      bus.o_addr    <= '0;
      bus.o_data    <= '0;
      bus.o_we      <= 1'b0;
      bus.o_start   <= 1'b0;
      bus.m_valid   <= 1'b0;
      bus.m_result  <= '0;
      bus.m_cout    <= 1'b0;
      bus.o_timeout <= 1'b0;
    end else begin
      bus.o_we      <= 1'b0;
      bus.o_data    <= '0;
      bus.o_start   <= 1'b0;
      bus.o_timeout <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.s_valid && bus.s_ready) begin
            data1       <= bus.s_data1;
            data2       <= bus.s_data2;
            cin         <= bus.s_cin;
            bus.s_ready <= 1'b0;
            bus.o_we    <= 1'b1;
            bus.o_addr  <= 3'd1;
            bus.o_data  <= bus.s_data1;
            state       <= WR_D1;
          end else begin
            bus.s_ready <= 1'b1;
            bus.o_addr  <= '0;
          end
        end
        WR_D1, WR_D2, WR_CIN: begin
          wait_cnt <= '0;
          state    <= (state == WR_D1) ? ACK_D1 : (state == WR_D2) ? ACK_D2 : ACK_CIN;
        end
        ACK_D1, ACK_D2, ACK_CIN, WAIT_RDY: begin
          if (awaited) begin
            wait_cnt <= '0;
            case (state)
              ACK_D1: begin
                bus.o_we   <= 1'b1;
                bus.o_addr <= 3'd2;
                bus.o_data <= data2;
                state      <= WR_D2;
              end
              ACK_D2: begin
                bus.o_we   <= 1'b1;
                bus.o_addr <= 3'd3;
                bus.o_data <= {{(N-1){1'b0}}, cin};
                state      <= WR_CIN;
              end
              ACK_CIN: begin
                bus.o_start <= 1'b1;
                bus.o_addr  <= '0;
                state       <= START;
              end
              default: begin
                bus.o_addr <= 3'd4;
                state      <= RD_RES;
              end
            endcase
          end else if (wait_cnt == WAIT_LAST) begin
            wait_cnt      <= '0;
            bus.o_addr    <= '0;
            bus.o_timeout <= 1'b1;
            bus.s_ready   <= 1'b1;
            state         <= IDLE;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        START: begin
          wait_cnt <= '0;
          state    <= WAIT_RDY;
        end
        // Read data lags the address by one cycle, so each capture happens one state later.
        RD_RES: begin
          bus.o_addr <= 3'd5;
          state      <= RD_COUT;
        end
        RD_COUT: begin
          bus.m_result <= bus.i_data;
          state        <= RD_LAST;
        end
        RD_LAST: begin
          bus.m_cout  <= bus.i_data[0];
          bus.m_valid <= 1'b1;
          bus.o_addr  <= '0;
          state       <= OUT;
        end
        OUT: begin
          if (bus.m_ready) begin
            bus.m_valid <= 1'b0;
            bus.s_ready <= 1'b1;
            state       <= IDLE;
          end
        end
        default: begin
          bus.s_ready <= 1'b0;
          bus.o_addr  <= '0;
          bus.m_valid <= 1'b0;
          state       <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_adder_cmd_master.sv
// Randomised bench for adder_cmd_master: a register-file adder responder plus a
// per-command expected-output timeline that is compared against the DUT every cycle.
module tb_adder_cmd_master;
  localparam int N          = 4;
  localparam int TIMEOUT    = 15;
  localparam int MAX_CYCLES = 20000;
  localparam int TOTAL_OPS  = 8 + 80;

  typedef struct packed {
    logic         s_ready;
    logic [2:0]   addr;
    logic         we;
    logic [N-1:0] data;
    logic         start;
    logic         m_valid;
    logic [N-1:0] result;
    logic         cout;
    logic         timeout;
    logic         m_ready;
    logic         spur_ok;
    logic         in_wait;
  } exp_t;

  typedef struct {
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         cin;
    int           d1, d2, d3, r, h;
    bit           has_lit;
    logic [N-1:0] lit_res;
    logic         lit_cout;
    bit           rst_in_wait;
    bit           pin_latency;
    bit           pin_timeout;
  } op_t;

  logic i_clk;
  logic i_rstn;

  adder_cmd_master_if #(.N(N)) bus ();

  adder_cmd_master #(.N(N), .TIMEOUT(TIMEOUT)) dut (
    .i_clk  (i_clk),
    .i_rstn (i_rstn),
    .bus    (bus)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  exp_t         q[$];
  op_t          directed[$];
  int           checks, errors, cycle, ops_done;
  logic [N-1:0] regs[0:7];
  int           ack_dly[0:7];
  int           rdy_dly, ack_cd, rdy_cd;
  logic [N-1:0] rd_next;
  bit           rst_armed;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s at cycle %0d: actual 0x%0h required 0x%0h", name, cycle, act, req);
    end
  endtask

  function automatic exp_t idle_entry();
    exp_t e;
    e         = '0;
    e.s_ready = 1'b1;
    e.spur_ok = 1'b1;
    return e;
  endfunction

  function automatic op_t mk_op(input logic [N-1:0] a, input logic [N-1:0] b, input logic cin,
                                input int d1, input int d2, input int d3, input int r, input int h);
    op_t op;
    op = '{a: a, b: b, cin: cin, d1: d1, d2: d2, d3: d3, r: r, h: h, has_lit: 1'b0,
           lit_res: '0, lit_cout: 1'b0, rst_in_wait: 1'b0, pin_latency: 1'b0, pin_timeout: 1'b0};
    return op;
  endfunction

  // Mostly short delays, occasionally withheld (-1) or right at the timeout boundary.
  function automatic int pick_dly(input int boundary);
    int x;
    x = int'($urandom_range(19));
    if (x == 0) return -1;
    if (x == 1) return boundary - 1;
    if (x == 2) return boundary;
    return x % 4;
  endfunction

  function automatic op_t rand_op();
    op_t op;
    op = mk_op(N'($urandom), N'($urandom), 1'($urandom), pick_dly(TIMEOUT), pick_dly(TIMEOUT),
               pick_dly(TIMEOUT), pick_dly(TIMEOUT - 1), int'($urandom_range(3)));
    return op;
  endfunction

  task automatic push_abort(input op_t op, input int base);
    exp_t e;
    e         = idle_entry();
    e.timeout = 1'b1;
    q.push_back(e);
    if (op.pin_timeout) chk("model_timeout_len", q.size() - base, TIMEOUT + 2);
  endtask

  // Expected per-cycle outputs for one accepted command, given the delays the responder will use.
  task automatic build(input op_t op);
    exp_t     e;
    logic [N:0] total;
    int       base, d;
    base  = q.size();
    total = {1'b0, op.a} + {1'b0, op.b} + {{N{1'b0}}, op.cin};
    if (op.has_lit) begin
      chk("model_res", total[N-1:0], op.lit_res);
      chk("model_cout", total[N], op.lit_cout);
    end
    for (int k = 1; k <= 3; k++) begin
      e      = '0;
      e.addr = 3'(k);
      e.we   = 1'b1;
      e.data = (k == 1) ? op.a : (k == 2) ? op.b : {{(N-1){1'b0}}, op.cin};
      q.push_back(e);
      e.we   = 1'b0;
      e.data = '0;
      d = (k == 1) ? op.d1 : (k == 2) ? op.d2 : op.d3;
      if (d < 0 || d + 1 > TIMEOUT) begin
        repeat (TIMEOUT) q.push_back(e);
        push_abort(op, base);
        return;
      end
      repeat (d + 1) q.push_back(e);
    end
    e       = '0;
    e.start = 1'b1;
    q.push_back(e);
    e.start   = 1'b0;
    e.in_wait = 1'b1;
    if (op.r < 0 || op.r + 2 > TIMEOUT) begin
      repeat (TIMEOUT) q.push_back(e);
      push_abort(op, base);
      return;
    end
    repeat (op.r + 2) q.push_back(e);
    e         = '0;
    e.spur_ok = 1'b1;
    e.addr    = 3'd4;
    q.push_back(e);
    e.addr = 3'd5;
    q.push_back(e);
    q.push_back(e);
    if (op.pin_latency) chk("model_latency", q.size() - base, 12);
    e         = '0;
    e.spur_ok = 1'b1;
    e.m_valid = 1'b1;
    e.result  = total[N-1:0];
    e.cout    = total[N];
    repeat (op.h) q.push_back(e);
    e.m_ready = 1'b1;
    q.push_back(e);
  endtask

  task automatic check_output(input exp_t e);
    chk("s_ready", bus.s_ready, e.s_ready);
    chk("o_addr", bus.o_addr, e.addr);
    chk("o_we", bus.o_we, e.we);
    chk("o_data", bus.o_data, e.data);
    chk("o_start", bus.o_start, e.start);
    chk("m_valid", bus.m_valid, e.m_valid);
    chk("o_timeout", bus.o_timeout, e.timeout);
    if (e.m_valid) begin
      chk("m_result", bus.m_result, e.result);
      chk("m_cout", bus.m_cout, e.cout);
    end
  endtask

  task automatic check_reset_outputs();
    chk("rst_s_ready", bus.s_ready, 1'b0);
    chk("rst_o_addr", bus.o_addr, 3'd0);
    chk("rst_o_we", bus.o_we, 1'b0);
    chk("rst_o_data", bus.o_data, '0);
    chk("rst_o_start", bus.o_start, 1'b0);
    chk("rst_m_valid", bus.m_valid, 1'b0);
    chk("rst_m_result", bus.m_result, '0);
    chk("rst_m_cout", bus.m_cout, 1'b0);
    chk("rst_o_timeout", bus.o_timeout, 1'b0);
  endtask

  task automatic clear_inputs();
    bus.s_valid = 1'b0;
    bus.s_data1 = '0;
    bus.s_data2 = '0;
    bus.s_cin   = 1'b0;
    bus.i_data  = '0;
    bus.i_ack   = 1'b0;
    bus.i_ready = 1'b0;
    bus.m_ready = 1'b0;
    ack_cd      = -1;
    rdy_cd      = -1;
    rd_next     = '0;
  endtask

  // Adder model: registered read data, ack after a write, ready after start.
  task automatic respond(input exp_t cur);
    logic [N:0] s;
    bus.i_ack   = 1'b0;
    bus.i_ready = 1'b0;
    if (ack_cd == 0) bus.i_ack = 1'b1;
    if (ack_cd >= 0) ack_cd--;
    if (rdy_cd == 0) bus.i_ready = 1'b1;
    if (rdy_cd >= 0) rdy_cd--;
    bus.i_data = rd_next;
    rd_next    = (!bus.o_we && bus.o_addr >= 3'd1 && bus.o_addr <= 3'd5) ? regs[bus.o_addr] : '0;
    if (bus.o_we && bus.o_addr >= 3'd1 && bus.o_addr <= 3'd3) begin
      regs[bus.o_addr] = bus.o_data;
      if (ack_dly[bus.o_addr] >= 0) ack_cd = ack_dly[bus.o_addr];
    end
    if (bus.o_start) begin
      s       = {1'b0, regs[1]} + {1'b0, regs[2]} + {{N{1'b0}}, regs[3][0]};
      regs[4] = s[N-1:0];
      regs[5] = {{(N-1){1'b0}}, s[N]};
      if (rdy_dly >= 0) rdy_cd = rdy_dly + 1;
    end
    if (cur.spur_ok && $urandom_range(3) == 0) bus.i_ack = 1'b1;
    if (cur.spur_ok && $urandom_range(3) == 0) bus.i_ready = 1'b1;
  endtask

  task automatic apply_stimulus(input exp_t cur);
    op_t op;
    bus.m_ready = cur.m_valid ? cur.m_ready : 1'($urandom);
    op          = rand_op();
    if (directed.size() != 0) begin
      op          = directed[0];
      bus.s_valid = 1'b1;
    end else if (ops_done < TOTAL_OPS) begin
      bus.s_valid = ($urandom_range(2) != 0);
    end else begin
      bus.s_valid = 1'b0;
    end
    bus.s_data1 = op.a;
    bus.s_data2 = op.b;
    bus.s_cin   = op.cin;
    if (cur.s_ready && bus.s_valid) begin
      if (directed.size() != 0) directed.delete(0);
      ack_dly[1] = op.d1;
      ack_dly[2] = op.d2;
      ack_dly[3] = op.d3;
      rdy_dly    = op.r;
      rst_armed  = op.rst_in_wait;
      ops_done++;
      build(op);
    end
  endtask

  task automatic reset_mid_op();
    i_rstn = 1'b0;
    #1;
    check_reset_outputs();
    q.delete();
    rst_armed = 1'b0;
    clear_inputs();
    @(negedge i_clk);
    i_rstn = 1'b1;
  endtask

  task automatic cycle_step();
    exp_t cur;
    @(negedge i_clk);
    cycle++;
    cur = (q.size() != 0) ? q.pop_front() : idle_entry();
    check_output(cur);
    if (cur.in_wait && rst_armed) begin
      reset_mid_op();
      return;
    end
    respond(cur);
    apply_stimulus(cur);
  endtask

  initial begin
    op_t op;
    checks    = 0;
    errors    = 0;
    cycle     = 0;
    ops_done  = 0;
    rst_armed = 1'b0;
    rdy_dly   = 0;
    for (int i = 0; i < 8; i++) begin
      regs[i]    = '0;
      ack_dly[i] = 0;
    end
    clear_inputs();
    i_rstn = 1'b0;

    op = mk_op(4'h7, 4'h5, 1'b0, 0, 0, 0, 0, 0);
    op.has_lit = 1'b1; op.lit_res = 4'hC; op.lit_cout = 1'b0; op.pin_latency = 1'b1;
    directed.push_back(op);
    op = mk_op(4'hF, 4'h1, 1'b1, 0, 0, 0, 0, 0);
    op.has_lit = 1'b1; op.lit_res = 4'h1; op.lit_cout = 1'b1;
    directed.push_back(op);
    op = mk_op(4'h4, 4'h4, 1'b0, -1, 0, 0, 0, 0);
    op.pin_timeout = 1'b1;
    directed.push_back(op);
    op = mk_op(4'h9, 4'h6, 1'b1, TIMEOUT - 1, 0, 0, 0, 0);
    op.has_lit = 1'b1; op.lit_res = 4'h0; op.lit_cout = 1'b1;
    directed.push_back(op);
    op = mk_op(4'hA, 4'h3, 1'b0, 0, 0, 0, 0, 5);
    op.has_lit = 1'b1; op.lit_res = 4'hD; op.lit_cout = 1'b0;
    directed.push_back(op);
    op = mk_op(4'h5, 4'h5, 1'b1, 1, 2, 0, TIMEOUT - 2, 1);
    op.has_lit = 1'b1; op.lit_res = 4'hB; op.lit_cout = 1'b0;
    directed.push_back(op);
    op = mk_op(4'h2, 4'h9, 1'b0, 0, 0, 0, 10, 0);
    op.rst_in_wait = 1'b1;
    directed.push_back(op);
    op = mk_op(4'h3, 4'h3, 1'b0, 0, 0, 0, 0, 0);
    op.has_lit = 1'b1; op.lit_res = 4'h6; op.lit_cout = 1'b0;
    directed.push_back(op);

    repeat (3) @(negedge i_clk);
    check_reset_outputs();
    i_rstn = 1'b1;

    while ((ops_done < TOTAL_OPS || q.size() != 0) && cycle < MAX_CYCLES) cycle_step();
    if (cycle >= MAX_CYCLES) begin
      checks++;
      errors++;
      $display("[TB] FAIL cycle_budget: actual %0d cycles, required under %0d", cycle, MAX_CYCLES);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
